regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Integer register file that consumes the writeback stage's outputs: write enable, write address and write data.
- Provides two combinational read ports to decode, with same-cycle writeback-to-read bypass.
- Holds a per-register busy scoreboard. Decode sets a bit when it issues a long-latency producer (load); writeback clears it.
- The hazard unit uses the busy flags to stall. The block sits between the decode and writeback stages of the 32-bit pipeline.

Parameters:
DATA_W, 32, register width in bits
NREG, 32, number of architectural registers; x0 is hardwired to zero
ADDR_W, 5, register index width; NREG = 2**ADDR_W

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
op_write  input  1  writeback enable from the writeback stage
write_addr  input  32  writeback destination; only bits [ADDR_W-1:0] are used, upper bits ignored
write_data  input  DATA_W  writeback value
rs1_addr  input  ADDR_W  read port 1 index
rs2_addr  input  ADDR_W  read port 2 index
rs1_data  output  DATA_W  read port 1 value (combinational)
rs2_data  output  DATA_W  read port 2 value (combinational)
rs1_busy  output  1  rs1 has an outstanding unwritten producer
rs2_busy  output  1  rs2 has an outstanding unwritten producer
mark_en  input  1  decode issues a producer whose result arrives later
mark_addr  input  ADDR_W  destination register of the marked producer
busy_vec  output  NREG  registered scoreboard state, bit i = register i busy

Behaviour:
- Reset: on a rising clk edge with rst=1, all registers clear to 0 and busy_vec clears to 0. op_write and mark_en are ignored in that cycle. Outputs reflect the cleared state in the following cycle.
- Reset asserted mid-operation discards any pending busy bits; no write completes on the reset edge.
- Write: on a rising edge with op_write=1 and wa=write_addr[ADDR_W-1:0]≠0, reg[wa] <= write_data. Writes to x0 are dropped.
- Read: rsN_data is combinational with zero added latency.
  - rsN_addr=0 gives 0.
  - Else, if op_write=1 and wa=rsN_addr, the output is write_data (bypass, write-first).
  - Else the output is reg[rsN_addr].
  - Both ports may address the same register, and both get the bypass.
- Scoreboard update at the rising edge, per register i≠0:
  - set = mark_en && mark_addr==i
  - clr = op_write && wa==i
  - set=1 gives busy[i] <= 1. A set in the same cycle as a clear wins, because the new producer is younger than the completing write.
  - set=0 and clr=1 gives busy[i] <= 0.
  - Otherwise busy[i] holds.
- busy[0] is constant 0; mark_en with mark_addr=0 has no effect.
- rsN_busy = busy[rsN_addr] && !(op_write && wa==rsN_addr) && rsN_addr≠0.
  - A clear in the current cycle masks busy, consistent with the data bypass.
  - A mark in the current cycle does not affect rsN_busy; it is visible from the next cycle.
- A write to a register that is not busy is legal: data updates and busy stays 0.
- A repeated mark on an already-busy register keeps it busy; there is no counting. One writeback clears it.
- busy_vec is the registered state only, with no bypass.

Test Plan:
1. Reset, then read rs1=5, rs2=31 -> rs1_data=0, rs2_data=0, rs1_busy=0, busy_vec=0.
2. op_write=1, write_addr=32'h00000025 (index 5), write_data=32'hDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data=DEADBEEF that cycle (bypass). Next cycle with op_write=0 -> still DEADBEEF (array).
3. op_write=1, write_addr=0, write_data=32'h12345678, then read rs1_addr=0 -> 0 in both cycles. mark_en with mark_addr=0 -> busy_vec=0.
4. mark_en=1, mark_addr=7 at edge T. At T+1, rs2_addr=7 -> rs2_busy=1, busy_vec[7]=1. At T+3, op_write=1, wa=7, data=32'hA5A5A5A5 -> rs2_busy=0 and rs2_data=A5A5A5A5 in that same cycle; busy_vec[7]=0 after the edge.
5. With busy[9]=1, assert mark_en=1, mark_addr=9 and op_write=1, wa=9 in the same cycle -> busy_vec[9]=1 after the edge, and reg[9] holds the new write_data.
6. Set busy[3] and busy[4], write reg[3]=32'h1, then assert rst=1 for one cycle -> busy_vec=0 and reg[3]=0 after the edge. An op_write on the reset edge leaves its target at 0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback side bus of the register file and busy scoreboard
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
);
  // writeback stage
  logic              op_write;
  logic [31:0]       write_addr;
  logic [DATA_W-1:0] write_data;
  // decode read ports
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  // decode producer marking
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  // registered scoreboard state for the hazard unit
  logic [NREG-1:0]   busy_vec;

  modport master (
    output op_write, write_addr, write_data,
    output rs1_addr, rs2_addr, mark_en, mark_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );

  modport slave (
    input  op_write, write_addr, write_data,
    input  rs1_addr, rs2_addr, mark_en, mark_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with writeback bypass and per-register busy scoreboard
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_W-1:0] wa;
  logic              wr_hit;
  logic              unused_addr_hi;

  // Only the low index bits of the writeback address select a register.
  assign wa             = bus.write_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.write_addr[31:ADDR_W];
  // x0 is never written, so a write to it is simply dropped.
  assign wr_hit         = bus.op_write && (wa != '0);

  // Register array: cleared on reset, writeback updates the destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wa] <= bus.write_data;
    end
  end

  // Read port 1: x0 reads zero, otherwise the same-cycle writeback wins over the array.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0) begin
      bus.rs1_data = '0;
    end else if (bus.op_write && (wa == bus.rs1_addr)) begin
      bus.rs1_data = bus.write_data;
    end
  end

  // Read port 2: same selection as port 1, independent index.
  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0) begin
      bus.rs2_data = '0;
    end else if (bus.op_write && (wa == bus.rs2_addr)) begin
      bus.rs2_data = bus.write_data;
    end
  end

  // Scoreboard next state: writeback clears, then a mark sets so a younger producer wins.
  always_comb begin
    busy_next = busy;
    if (bus.op_write) begin
      busy_next[wa] = 1'b0;
    end
    if (bus.mark_en) begin
      busy_next[bus.mark_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state: reset discards every outstanding producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A completing writeback masks busy like the data bypass; a fresh mark shows next cycle.
  assign bus.rs1_busy = busy[bus.rs1_addr] && !(bus.op_write && (wa == bus.rs1_addr))
                        && (bus.rs1_addr != '0);
  assign bus.rs2_busy = busy[bus.rs2_addr] && !(bus.op_write && (wa == bus.rs2_addr))
                        && (bus.rs2_addr != '0);
  assign bus.busy_vec = busy;

endmodule
